// File: rtl/exec_ctrl_unit.sv
// exec_ctrl_unit: decode, ALU and branch resolution for the single-cycle
// MIPS-subset CPU, plus free-running cycle/branch statistics counters.
module exec_ctrl_unit #(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] SYSC_LED = 32'd34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             jal,
    output logic             jmp,
    output logic             jr,
    output logic             syscall,
    output logic [31:0]      alu_result1,
    output logic [31:0]      alu_result2,
    output logic             alu_equal,
    output logic             cond_taken,
    output logic             uncond_taken,
    output logic             halt,
    output logic             led_en,
    output logic [CNT_W-1:0] total_cycles,
    output logic [CNT_W-1:0] condi_branch_num,
    output logic [CNT_W-1:0] uncondi_branch_num
);
    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRA, ALU_SRL, ALU_MUL, ALU_DIV, ALU_ADD, ALU_SUB,
        ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } alu_op_t;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    alu_op_t     alu_op;
    logic        use_imm;
    logic        imm_zext;
    logic        r_alu;
    logic        is_beq;
    logic        is_bne;
    logic        is_bgez;
    logic [31:0] imm_ext;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [63:0] prod;
    logic        unused_ok;

    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign shamt     = instr[10:6];
    // rs/rd register numbers are consumed by the regfile, not here
    assign unused_ok = ^instr[25:21];

    always_comb begin
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        jal        = 1'b0;
        jmp        = 1'b0;
        jr         = 1'b0;
        syscall    = 1'b0;
        alu_op     = ALU_ADD;
        use_imm    = 1'b0;
        imm_zext   = 1'b0;
        r_alu      = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_bgez    = 1'b0;
        case (opcode)
            6'h00: begin
                r_alu = 1'b1;
                case (funct)
                    6'h20, 6'h21: alu_op = ALU_ADD;
                    6'h22, 6'h23: alu_op = ALU_SUB;
                    6'h24: alu_op = ALU_AND;
                    6'h25: alu_op = ALU_OR;
                    6'h26: alu_op = ALU_XOR;
                    6'h27: alu_op = ALU_NOR;
                    6'h2A: alu_op = ALU_SLT;
                    6'h2B: alu_op = ALU_SLTU;
                    6'h00: alu_op = ALU_SLL;
                    6'h03: alu_op = ALU_SRA;
                    6'h02: alu_op = ALU_SRL;
                    6'h18: alu_op = ALU_MUL;
                    6'h1A: alu_op = ALU_DIV;
                    6'h08: begin
                        r_alu = 1'b0;
                        jr    = 1'b1;
                    end
                    6'h0C: begin
                        r_alu   = 1'b0;
                        syscall = 1'b1;
                    end
                    default: r_alu = 1'b0;
                endcase
                reg_write = r_alu;
                reg_dst   = r_alu;
            end
            6'h01: is_bgez = (instr[20:16] == 5'd1);
            6'h02: jmp = 1'b1;
            6'h03: begin
                jal       = 1'b1;
                reg_write = 1'b1;
            end
            6'h04: begin
                is_beq = 1'b1;
                alu_op = ALU_SUB;
            end
            6'h05: begin
                is_bne = 1'b1;
                alu_op = ALU_SUB;
            end
            6'h08, 6'h09: begin
                use_imm   = 1'b1;
                reg_write = 1'b1;
            end
            6'h0A: begin
                alu_op    = ALU_SLT;
                use_imm   = 1'b1;
                reg_write = 1'b1;
            end
            6'h0C: begin
                alu_op    = ALU_AND;
                use_imm   = 1'b1;
                imm_zext  = 1'b1;
                reg_write = 1'b1;
            end
            6'h0D: begin
                alu_op    = ALU_OR;
                use_imm   = 1'b1;
                imm_zext  = 1'b1;
                reg_write = 1'b1;
            end
            6'h23: begin
                use_imm    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            6'h2B: begin
                use_imm   = 1'b1;
                mem_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm_ext = imm_zext ? {16'd0, instr[15:0]}
                              : {{16{instr[15]}}, instr[15:0]};
    assign alu_a   = rs_data;
    assign alu_b   = use_imm ? imm_ext : rt_data;
    assign sa      = alu_a;
    assign sb      = alu_b;
    assign prod    = $signed({{32{alu_a[31]}}, alu_a})
                   * $signed({{32{alu_b[31]}}, alu_b});

    always_comb begin
        alu_result1 = 32'd0;
        alu_result2 = 32'd0;
        case (alu_op)
            ALU_SLL:  alu_result1 = alu_b << shamt;
            ALU_SRA:  alu_result1 = sb >>> shamt;
            ALU_SRL:  alu_result1 = alu_b >> shamt;
            ALU_MUL:  {alu_result2, alu_result1} = prod;
            ALU_DIV: begin
                // divide by zero leaves the dividend as the remainder
                if (alu_b != 32'd0) begin
                    alu_result1 = sa / sb;
                    alu_result2 = sa % sb;
                end else begin
                    alu_result2 = alu_a;
                end
            end
            ALU_SUB:  alu_result1 = alu_a - alu_b;
            ALU_AND:  alu_result1 = alu_a & alu_b;
            ALU_OR:   alu_result1 = alu_a | alu_b;
            ALU_XOR:  alu_result1 = alu_a ^ alu_b;
            ALU_NOR:  alu_result1 = ~(alu_a | alu_b);
            ALU_SLT:  alu_result1 = {31'd0, sa < sb};
            ALU_SLTU: alu_result1 = {31'd0, alu_a < alu_b};
            default:  alu_result1 = alu_a + alu_b;
        endcase
    end

    assign alu_equal    = (alu_a == alu_b);
    assign cond_taken   = (is_beq & alu_equal) | (is_bne & ~alu_equal)
                        | (is_bgez & ~rs_data[31]);
    assign uncond_taken = jmp | jal | jr;
    assign halt         = syscall & (rs_data != SYSC_LED);
    assign led_en       = syscall & (rs_data == SYSC_LED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_cycles       <= '0;
            condi_branch_num   <= '0;
            uncondi_branch_num <= '0;
        end else if (run_en) begin
            total_cycles <= total_cycles + CNT_W'(1);
            if (cond_taken)
                condi_branch_num <= condi_branch_num + CNT_W'(1);
            if (uncond_taken)
                uncondi_branch_num <= uncondi_branch_num + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_exec_ctrl_unit.sv
// tb_exec_ctrl_unit: directed and randomized checks of exec_ctrl_unit
// against an instruction-level reference model.
module tb_exec_ctrl_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_en = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;

    logic mem_to_reg, mem_write, reg_write, reg_dst;
    logic jal, jmp, jr, syscall;
    logic [31:0] alu_result1, alu_result2;
    logic alu_equal, cond_taken, uncond_taken, halt, led_en;
    logic [31:0] total_cycles, condi_branch_num, uncondi_branch_num;

    logic s_mem_to_reg, s_mem_write, s_reg_write, s_reg_dst;
    logic s_jal, s_jmp, s_jr, s_syscall;
    logic [31:0] s_alu_result1, s_alu_result2;
    logic s_alu_equal, s_cond_taken, s_uncond_taken, s_halt, s_led_en;
    logic [3:0] s_total_cycles, s_condi_branch_num, s_uncondi_branch_num;

    int n_vec = 0;
    int n_bad = 0;
    int unsigned e_tot = 0;
    int unsigned e_cnd = 0;
    int unsigned e_unc = 0;

    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  flags;
    } exp_t;

    logic [5:0]  ops [17] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03,
                              6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C,
                              6'h0D, 6'h23, 6'h2B, 6'h3F, 6'h0F};
    logic [5:0]  fns [19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                              6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02,
                              6'h03, 6'h18, 6'h1A, 6'h08, 6'h0C, 6'h3F,
                              6'h01};
    logic [31:0] specials [7] = '{32'd0, 32'd1, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'h7FFF_FFFF,
                                  32'd34, 32'd10};

    exec_ctrl_unit u_dut (
        .clk(clk), .rst(rst), .run_en(run_en), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst),
        .jal(jal), .jmp(jmp), .jr(jr), .syscall(syscall),
        .alu_result1(alu_result1), .alu_result2(alu_result2),
        .alu_equal(alu_equal), .cond_taken(cond_taken),
        .uncond_taken(uncond_taken), .halt(halt), .led_en(led_en),
        .total_cycles(total_cycles),
        .condi_branch_num(condi_branch_num),
        .uncondi_branch_num(uncondi_branch_num)
    );

    exec_ctrl_unit #(.CNT_W(4)) u_small (
        .clk(clk), .rst(rst), .run_en(run_en), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data),
        .mem_to_reg(s_mem_to_reg), .mem_write(s_mem_write),
        .reg_write(s_reg_write), .reg_dst(s_reg_dst),
        .jal(s_jal), .jmp(s_jmp), .jr(s_jr), .syscall(s_syscall),
        .alu_result1(s_alu_result1), .alu_result2(s_alu_result2),
        .alu_equal(s_alu_equal), .cond_taken(s_cond_taken),
        .uncond_taken(s_uncond_taken), .halt(s_halt), .led_en(s_led_en),
        .total_cycles(s_total_cycles),
        .condi_branch_num(s_condi_branch_num),
        .uncondi_branch_num(s_uncondi_branch_num)
    );

    always #5 clk = ~clk;

    // Instruction-level reference: what each opcode means, in plain arithmetic
    function automatic exp_t model(input logic [31:0] i, a, b);
        exp_t e;
        logic [5:0] op, fn;
        logic [4:0] sh;
        logic [31:0] bv, se, ze;
        longint sa, sb, p;
        logic m2r, mw, rw, rd, jl, jp, jrr, sc, beq, bne, bz, eq, cnd;
        op = i[31:26]; fn = i[5:0]; sh = i[10:6];
        se = {{16{i[15]}}, i[15:0]};
        ze = {16'd0, i[15:0]};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        bv = b;
        {m2r, mw, rw, rd, jl, jp, jrr, sc, beq, bne, bz} = '0;
        e.r1 = a + b;
        e.r2 = 32'd0;
        case (op)
            6'h00: begin
                rw = 1'b1; rd = 1'b1;
                case (fn)
                    6'h20, 6'h21: e.r1 = a + b;
                    6'h22, 6'h23: e.r1 = a - b;
                    6'h24: e.r1 = a & b;
                    6'h25: e.r1 = a | b;
                    6'h26: e.r1 = a ^ b;
                    6'h27: e.r1 = ~(a | b);
                    6'h2A: e.r1 = (sa < sb) ? 32'd1 : 32'd0;
                    6'h2B: e.r1 = (a < b) ? 32'd1 : 32'd0;
                    6'h00: e.r1 = b << sh;
                    6'h02: e.r1 = b >> sh;
                    6'h03: e.r1 = 32'(sb >>> sh);
                    6'h18: begin
                        p = sa * sb;
                        e.r1 = p[31:0];
                        e.r2 = p[63:32];
                    end
                    6'h1A: begin
                        if (b == 32'd0) begin
                            e.r1 = 32'd0;
                            e.r2 = a;
                        end else begin
                            e.r1 = 32'(sa / sb);
                            e.r2 = 32'(sa % sb);
                        end
                    end
                    6'h08: begin rw = 1'b0; rd = 1'b0; jrr = 1'b1; end
                    6'h0C: begin rw = 1'b0; rd = 1'b0; sc = 1'b1; end
                    default: begin rw = 1'b0; rd = 1'b0; end
                endcase
            end
            6'h01: bz = (i[20:16] == 5'd1);
            6'h02: jp = 1'b1;
            6'h03: begin jl = 1'b1; rw = 1'b1; end
            6'h04: begin beq = 1'b1; e.r1 = a - b; end
            6'h05: begin bne = 1'b1; e.r1 = a - b; end
            6'h08, 6'h09: begin bv = se; e.r1 = a + se; rw = 1'b1; end
            6'h0A: begin
                bv = se; rw = 1'b1;
                e.r1 = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
            end
            6'h0C: begin bv = ze; e.r1 = a & ze; rw = 1'b1; end
            6'h0D: begin bv = ze; e.r1 = a | ze; rw = 1'b1; end
            6'h23: begin bv = se; e.r1 = a + se; rw = 1'b1; m2r = 1'b1; end
            6'h2B: begin bv = se; e.r1 = a + se; mw = 1'b1; end
            default: ;
        endcase
        eq = (a == bv);
        cnd = (beq && eq) || (bne && !eq) || (bz && !a[31]);
        e.ctl = {m2r, mw, rw, rd, jl, jp, jrr, sc};
        e.flags = {eq, cnd, jp | jl | jrr, sc && a != 32'd34, sc && a == 32'd34};
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0] op;
        r = $urandom;
        op = ops[$urandom_range(0, 16)];
        r[31:26] = op;
        if (op == 6'h00) r[5:0] = fns[$urandom_range(0, 18)];
        if (op == 6'h01 && $urandom_range(0, 3) != 0) r[20:16] = 5'd1;
        return r;
    endfunction

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 1) == 0) return $urandom;
        return specials[$urandom_range(0, 6)];
    endfunction

    task automatic test_reset();
        rst = 1'b1; run_en = 1'b1; instr = 32'h0000_0020;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({total_cycles, condi_branch_num, uncondi_branch_num} !== 96'd0) begin
            n_bad++;
            $display("FAIL reset_counters: got %h/%h/%h want 0/0/0",
                     total_cycles, condi_branch_num, uncondi_branch_num);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_counters();
        instr = 32'h0000_0020; rs_data = 0; rt_data = 0; run_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (total_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %0d want 0", total_cycles);
        end
        #1 rst = 1'b0;
        e_tot = 0; e_cnd = 0; e_unc = 0;
        repeat (5) @(posedge clk);
        #1;
        e_tot = 5;
        n_vec++;
        if (total_cycles !== e_tot) begin
            n_bad++;
            $display("FAIL count_5: got %0d want %0d", total_cycles, e_tot);
        end
        @(negedge clk);
        run_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (total_cycles !== e_tot) begin
            n_bad++;
            $display("FAIL hold_disabled: got %0d want %0d", total_cycles, e_tot);
        end
    endtask

    task automatic test_directed();
        @(negedge clk);
        run_en = 1'b0;
        instr = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
        rs_data = 32'd7; rt_data = 32'hFFFF_FFF7;
        #1;
        n_vec++;
        if ({alu_result1, reg_write, reg_dst} !== {32'hFFFF_FFFE, 2'b11}) begin
            n_bad++;
            $display("FAIL add: got %h rw=%b rd=%b want fffffffe 1 1",
                     alu_result1, reg_write, reg_dst);
        end
        instr = {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h18};
        rs_data = 32'h8000_0000; rt_data = 32'd2;
        #1;
        n_vec++;
        if ({alu_result2, alu_result1} !== 64'hFFFF_FFFF_0000_0000) begin
            n_bad++;
            $display("FAIL mul: got %h_%h want ffffffff_00000000",
                     alu_result2, alu_result1);
        end
        instr = {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h1A};
        rs_data = 32'd7; rt_data = 32'd0;
        #1;
        n_vec++;
        if ({alu_result1, alu_result2} !== {32'd0, 32'd7}) begin
            n_bad++;
            $display("FAIL div0: got q=%h r=%h want 0 7", alu_result1, alu_result2);
        end
        instr = 32'h0000_000C; rs_data = 32'd34;
        #1;
        n_vec++;
        if ({led_en, halt} !== 2'b10) begin
            n_bad++;
            $display("FAIL sys_led: got led=%b halt=%b want 1 0", led_en, halt);
        end
        rs_data = 32'd10;
        #1;
        n_vec++;
        if ({led_en, halt} !== 2'b01) begin
            n_bad++;
            $display("FAIL sys_halt: got led=%b halt=%b want 0 1", led_en, halt);
        end
        instr = {6'h03, 26'h0000_040};
        #1;
        n_vec++;
        if ({uncond_taken, reg_write} !== 2'b11) begin
            n_bad++;
            $display("FAIL jal: got unc=%b rw=%b want 1 1", uncond_taken, reg_write);
        end
        run_en = 1'b1;
        instr = {6'h04, 5'd1, 5'd2, 16'd3};
        rs_data = 32'd5; rt_data = 32'd5;
        #1;
        n_vec++;
        if (cond_taken !== 1'b1) begin
            n_bad++;
            $display("FAIL beq_taken: got %b want 1", cond_taken);
        end
        @(posedge clk);
        #1;
        e_tot++; e_cnd++;
        n_vec++;
        if (condi_branch_num !== e_cnd) begin
            n_bad++;
            $display("FAIL beq_count: got %0d want %0d", condi_branch_num, e_cnd);
        end
        @(negedge clk);
        instr = {6'h05, 5'd1, 5'd2, 16'd3};
        #1;
        n_vec++;
        if (cond_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL bne_taken: got %b want 0", cond_taken);
        end
        @(posedge clk);
        #1;
        e_tot++;
        n_vec++;
        if ({total_cycles, condi_branch_num} !== {e_tot, e_cnd}) begin
            n_bad++;
            $display("FAIL bne_count: got %0d/%0d want %0d/%0d",
                     total_cycles, condi_branch_num, e_tot, e_cnd);
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            instr = rand_instr();
            rs_data = pick();
            rt_data = ($urandom_range(0, 3) == 0) ? rs_data : pick();
            if (rs_data == 32'h8000_0000 && rt_data == 32'hFFFF_FFFF)
                rt_data = 32'd1;
            run_en = ($urandom_range(0, 3) != 0);
            e = model(instr, rs_data, rt_data);
            #1;
            n_vec++;
            if ({mem_to_reg, mem_write, reg_write, reg_dst,
                 jal, jmp, jr, syscall} !== e.ctl) begin
                n_bad++;
                $display("FAIL ctl: instr=%h got %b want %b", instr,
                         {mem_to_reg, mem_write, reg_write, reg_dst,
                          jal, jmp, jr, syscall}, e.ctl);
            end
            n_vec++;
            if ({alu_result1, alu_result2} !== {e.r1, e.r2}) begin
                n_bad++;
                $display("FAIL alu: instr=%h a=%h b=%h got %h_%h want %h_%h",
                         instr, rs_data, rt_data, alu_result1, alu_result2,
                         e.r1, e.r2);
            end
            n_vec++;
            if ({alu_equal, cond_taken, uncond_taken, halt, led_en} !== e.flags) begin
                n_bad++;
                $display("FAIL flags: instr=%h a=%h b=%h got %b want %b",
                         instr, rs_data, rt_data,
                         {alu_equal, cond_taken, uncond_taken, halt, led_en},
                         e.flags);
            end
            if (run_en) begin
                e_tot++;
                if (e.flags[3]) e_cnd++;
                if (e.flags[2]) e_unc++;
            end
            @(posedge clk);
            #1;
            n_vec++;
            if ({total_cycles, condi_branch_num, uncondi_branch_num}
                !== {e_tot, e_cnd, e_unc}) begin
                n_bad++;
                $display("FAIL counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                         total_cycles, condi_branch_num, uncondi_branch_num,
                         e_tot, e_cnd, e_unc);
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        run_en = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        instr = {6'h03, 26'd0}; rs_data = 0; rt_data = 0;
        run_en = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        n_vec++;
        if ({s_total_cycles, s_condi_branch_num, s_uncondi_branch_num}
            !== {4'd15, 4'd0, 4'd15}) begin
            n_bad++;
            $display("FAIL small_max: got %0d/%0d/%0d want 15/0/15",
                     s_total_cycles, s_condi_branch_num, s_uncondi_branch_num);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({s_total_cycles, s_uncondi_branch_num} !== 8'd0) begin
            n_bad++;
            $display("FAIL small_wrap: got %0d/%0d want 0/0",
                     s_total_cycles, s_uncondi_branch_num);
        end
        n_vec++;
        if (total_cycles !== 32'd16) begin
            n_bad++;
            $display("FAIL wide_no_wrap: got %0d want 16", total_cycles);
        end
        @(negedge clk);
        run_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_counters();
        test_directed();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
